// File: rtl/cop0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// cop0_exc_ctrl
//
// Coprocessor-0 exception/interrupt controller for the single-cycle MIPS core.
// Holds Status (12), Cause (13) and EPC (14). Services mfc0, mtc0 and eret.
// Arbitrates syscall traps against the external interrupt lines, and sequences
// trap entry and return through a four-state FSM:
//   RUN -> ENTER -> HANDLER -> RETURN -> RUN
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   InstrValid     : current instruction commits this cycle
//   PC             : PC of the current instruction
//   IsSyscall      : decode flag, syscall
//   IsCOP0         : decode flag, opcode 010000
//   Rs, Rd, Funct  : instruction fields (COP0 sub-op, CP0 register, function)
//   WData          : rt value written by mtc0
//   IrqReq         : level-sensitive interrupt requests (asynchronous)
//   RData          : mfc0 read data, combinational, 0 when not an mfc0
//   Flush          : kill RegWrite/MemWrite of the current instruction
//   Stall          : hold PC and block commit this cycle
//   PCRedirect     : load RedirectPC into PC at the next edge
//   RedirectPC     : redirect target (handler entry or EPC)
//   IntAck         : one-hot acknowledge of the interrupt being taken
//   InHandler      : mirror of Status.EXL
// ---------------------------------------------------------------------------
module cop0_exc_ctrl #(
    parameter int          NUM_IRQ      = 4,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               InstrValid,
    input  logic [31:0]        PC,
    input  logic               IsSyscall,
    input  logic               IsCOP0,
    input  logic [4:0]         Rs,
    input  logic [4:0]         Rd,
    input  logic [5:0]         Funct,
    input  logic [31:0]        WData,
    input  logic [NUM_IRQ-1:0] IrqReq,
    output logic [31:0]        RData,
    output logic               Flush,
    output logic               Stall,
    output logic               PCRedirect,
    output logic [31:0]        RedirectPC,
    output logic [NUM_IRQ-1:0] IntAck,
    output logic               InHandler
);

    // CP0 register numbers
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    // COP0 sub-operations encoded in Rs, and the eret function code
    localparam logic [4:0] RS_MFC0    = 5'b00000;
    localparam logic [4:0] RS_MTC0    = 5'b00100;
    localparam logic [4:0] RS_CO      = 5'b10000;
    localparam logic [5:0] FUNCT_ERET = 6'b011000;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e             state_q,       state_d;
    logic               ie_q,          ie_d;
    logic               exl_q,         exl_d;
    logic [NUM_IRQ-1:0] im_q,          im_d;
    logic [4:0]         exc_code_q,    exc_code_d;
    logic [31:0]        epc_q,         epc_d;
    logic [NUM_IRQ-1:0] ip_q,          ip_d;
    logic               stall_q,       stall_d;
    logic               pc_redirect_q, pc_redirect_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;

    // -----------------------------------------------------------------------
    // Decode and trap arbitration
    // -----------------------------------------------------------------------
    logic               is_mfc0;
    logic               is_mtc0;
    logic               is_eret;
    logic               in_run;
    logic               can_commit;
    logic [NUM_IRQ-1:0] pending;
    logic               int_take;
    logic               sys_take;
    logic               eret_take;
    logic               mtc0_we;
    logic [NUM_IRQ-1:0] ack_onehot;

    assign is_mfc0 = IsCOP0 && (Rs == RS_MFC0);
    assign is_mtc0 = InstrValid && IsCOP0 && (Rs == RS_MTC0);
    assign is_eret = InstrValid && IsCOP0 && (Rs == RS_CO) && (Funct == FUNCT_ERET);

    assign in_run     = (state_q == ST_RUN);
    // ENTER and RETURN stall the pipe, so nothing commits in those cycles.
    assign can_commit = (state_q == ST_RUN) || (state_q == ST_HANDLER);

    // Uses the pre-write Status: an mtc0 in this cycle only lands at the edge.
    assign pending  = ip_q & im_q;
    assign int_take = in_run && InstrValid && ie_q && !exl_q && (|pending);
    // Interrupt wins; the losing syscall is re-executed after the return.
    assign sys_take = in_run && InstrValid && IsSyscall && !exl_q && !int_take;
    assign eret_take = (state_q == ST_HANDLER) && is_eret;
    // A flushed instruction must not update CP0 state.
    assign mtc0_we  = is_mtc0 && can_commit && !int_take;

    // Lowest-index pending line wins the acknowledge.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        ack_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                ack_onehot    = '0;
                ack_onehot[i] = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Register read views
    // -----------------------------------------------------------------------
    logic [31:0] status_rd;
    logic [31:0] cause_rd;

    always_comb begin
        status_rd                = '0;
        status_rd[0]             = ie_q;
        status_rd[1]             = exl_q;
        status_rd[8 +: NUM_IRQ]  = im_q;

        cause_rd                 = '0;
        cause_rd[6:2]            = exc_code_q;
        cause_rd[8 +: NUM_IRQ]   = ip_q;
    end

    always_comb begin
        RData = '0;
        if (is_mfc0) begin
            unique case (Rd)
                REG_STATUS: RData = status_rd;
                REG_CAUSE:  RData = cause_rd;
                REG_EPC:    RData = epc_q;
                default:    RData = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ie_d          = ie_q;
        exl_d         = exl_q;
        im_d          = im_q;
        exc_code_d    = exc_code_q;
        epc_d         = epc_q;
        ip_d          = IrqReq;
        // Redirect outputs are single-cycle; they are re-armed only on entry
        // to ENTER or RETURN.
        stall_d       = 1'b0;
        pc_redirect_d = 1'b0;
        redirect_pc_d = '0;

        unique case (state_q)
            ST_RUN: begin
                if (int_take) begin
                    epc_d         = PC;
                    exc_code_d    = EXC_INT;
                    exl_d         = 1'b1;
                    state_d       = ST_ENTER;
                    stall_d       = 1'b1;
                    pc_redirect_d = 1'b1;
                    redirect_pc_d = HANDLER_ADDR;
                end else if (sys_take) begin
                    // Syscall completes, so the return lands on the next word.
                    epc_d         = PC + 32'd4;
                    exc_code_d    = EXC_SYS;
                    exl_d         = 1'b1;
                    state_d       = ST_ENTER;
                    stall_d       = 1'b1;
                    pc_redirect_d = 1'b1;
                    redirect_pc_d = HANDLER_ADDR;
                end
            end

            ST_ENTER: begin
                state_d = ST_HANDLER;
            end

            ST_HANDLER: begin
                // Syscalls and interrupts are ignored here; only eret leaves.
                if (eret_take) begin
                    exl_d         = 1'b0;
                    state_d       = ST_RETURN;
                    stall_d       = 1'b1;
                    pc_redirect_d = 1'b1;
                    // Target frozen at the eret commit.
                    redirect_pc_d = epc_q;
                end
            end

            ST_RETURN: begin
                state_d = ST_RUN;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Software writes. Decode keeps mtc0 exclusive with syscall/eret, and
        // an EXL write does not move the FSM.
        if (mtc0_we) begin
            unique case (Rd)
                REG_STATUS: begin
                    ie_d  = WData[0];
                    exl_d = WData[1];
                    im_d  = WData[8 +: NUM_IRQ];
                end
                REG_EPC: begin
                    epc_d = WData;
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            ie_q          <= 1'b0;
            exl_q         <= 1'b0;
            im_q          <= '0;
            exc_code_q    <= '0;
            epc_q         <= '0;
            ip_q          <= '0;
            stall_q       <= 1'b0;
            pc_redirect_q <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q       <= state_d;
            ie_q          <= ie_d;
            exl_q         <= exl_d;
            im_q          <= im_d;
            exc_code_q    <= exc_code_d;
            epc_q         <= epc_d;
            ip_q          <= ip_d;
            stall_q       <= stall_d;
            pc_redirect_q <= pc_redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign Flush      = int_take;
    assign IntAck     = int_take ? ack_onehot : '0;
    assign Stall      = stall_q;
    assign PCRedirect = pc_redirect_q;
    assign RedirectPC = redirect_pc_q;
    assign InHandler  = exl_q;

endmodule

// File: tb/tb_cop0_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cop0_exc_ctrl
//
// Stimulus drives one instruction per cycle and asks a behavioural model what
// the controller must show during that cycle; the answer is queued. A monitor
// on the falling edge pops each expectation and compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_cop0_exc_ctrl;

    localparam int          NIRQ = 4;
    localparam logic [31:0] HADDR = 32'h0000_0180;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            InstrValid = 1'b0;
    logic [31:0]     PC = '0;
    logic            IsSyscall = 1'b0;
    logic            IsCOP0 = 1'b0;
    logic [4:0]      Rs = '0;
    logic [4:0]      Rd = '0;
    logic [5:0]      Funct = '0;
    logic [31:0]     WData = '0;
    logic [NIRQ-1:0] IrqReq = '0;
    logic [31:0]     RData;
    logic            Flush;
    logic            Stall;
    logic            PCRedirect;
    logic [31:0]     RedirectPC;
    logic [NIRQ-1:0] IntAck;
    logic            InHandler;

    cop0_exc_ctrl #(.NUM_IRQ(NIRQ), .HANDLER_ADDR(HADDR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .InstrValid (InstrValid),
        .PC         (PC),
        .IsSyscall  (IsSyscall),
        .IsCOP0     (IsCOP0),
        .Rs         (Rs),
        .Rd         (Rd),
        .Funct      (Funct),
        .WData      (WData),
        .IrqReq     (IrqReq),
        .RData      (RData),
        .Flush      (Flush),
        .Stall      (Stall),
        .PCRedirect (PCRedirect),
        .RedirectPC (RedirectPC),
        .IntAck     (IntAck),
        .InHandler  (InHandler)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0]     rdata;
        logic            flush;
        logic            stall;
        logic            redirect;
        logic [31:0]     redirect_pc;
        logic [NIRQ-1:0] ack;
        logic            in_handler;
    } exp_t;

    exp_t exp_q[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("RData",      RData,              e.rdata);
                check("Flush",      32'(Flush),         32'(e.flush));
                check("Stall",      32'(Stall),         32'(e.stall));
                check("PCRedirect", 32'(PCRedirect),    32'(e.redirect));
                check("RedirectPC", RedirectPC,         e.redirect_pc);
                check("IntAck",     32'(IntAck),        32'(e.ack));
                check("InHandler",  32'(InHandler),     32'(e.in_handler));
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: architectural registers plus "a redirect is due
    // this cycle" and "software is inside a handler".
    // ------------------------------------------------------------------
    bit              m_ie, m_exl;
    logic [NIRQ-1:0] m_im, m_ip;
    logic [4:0]      m_code;
    logic [31:0]     m_epc;
    bit              m_redir, m_redir_to_handler, m_handling;
    logic [31:0]     m_redir_pc;

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_im = '0; m_ip = '0; m_code = '0; m_epc = '0;
        m_redir = 0; m_redir_to_handler = 0; m_handling = 0; m_redir_pc = '0;
    endtask

    task automatic model_trap(input logic [31:0] epc, input logic [4:0] code);
        m_epc = epc; m_code = code; m_exl = 1;
        m_redir = 1; m_redir_pc = HADDR; m_redir_to_handler = 1;
    endtask

    // One instruction slot: drive inputs after the edge, predict, advance.
    task automatic step(input bit iv, input logic [31:0] pc, input bit sys, input bit cop0,
                        input logic [4:0] rs, input logic [4:0] rd, input logic [5:0] fn,
                        input logic [31:0] wd, input logic [NIRQ-1:0] irq);
        exp_t            e;
        bit              running, itake, was_redir, found;
        logic [NIRQ-1:0] pend;
        @(posedge clk);
        #1;
        InstrValid = iv; PC = pc; IsSyscall = sys; IsCOP0 = cop0;
        Rs = rs; Rd = rd; Funct = fn; WData = wd; IrqReq = irq;

        running = !m_redir && !m_handling;
        pend    = m_ip & m_im;
        itake   = running && iv && m_ie && !m_exl && (pend != 0);
        e.ack   = '0;
        found   = 0;
        if (itake)
            for (int i = 0; i < NIRQ; i++)
                if (pend[i] && !found) begin e.ack[i] = 1'b1; found = 1; end
        e.flush       = itake;
        e.stall       = m_redir;
        e.redirect    = m_redir;
        e.redirect_pc = m_redir ? m_redir_pc : 32'h0;
        e.in_handler  = m_exl;
        e.rdata       = 32'h0;
        if (cop0 && rs == 5'd0) begin
            if (rd == 5'd12) e.rdata = 32'(m_ie) | (32'(m_exl) << 1) | (32'(m_im) << 8);
            if (rd == 5'd13) e.rdata = (32'(m_code) << 2) | (32'(m_ip) << 8);
            if (rd == 5'd14) e.rdata = m_epc;
        end
        exp_q.push_back(e);

        was_redir = m_redir;
        m_redir   = 0;
        if (was_redir)
            m_handling = m_redir_to_handler;
        else if (itake)
            model_trap(pc, 5'd0);
        else if (running && iv && sys && !m_exl)
            model_trap(pc + 32'd4, 5'd8);
        else if (m_handling && iv && cop0 && rs == 5'b10000 && fn == 6'b011000) begin
            m_exl = 0; m_redir = 1; m_redir_pc = m_epc; m_redir_to_handler = 0; m_handling = 0;
        end
        if (!was_redir && iv && cop0 && rs == 5'b00100 && !itake) begin
            if (rd == 5'd12) begin
                m_ie = wd[0]; m_exl = wd[1]; m_im = wd[8 +: NIRQ];
            end
            if (rd == 5'd14) m_epc = wd;
        end
        m_ip = irq;
    endtask

    // Instruction shorthands
    task automatic nop(input logic [31:0] pc, input logic [NIRQ-1:0] irq);
        step(1, pc, 0, 0, 5'd0, 5'd0, 6'd0, 32'h0, irq);
    endtask
    task automatic sysc(input logic [31:0] pc, input logic [NIRQ-1:0] irq);
        step(1, pc, 1, 0, 5'd0, 5'd0, 6'd0, 32'h0, irq);
    endtask
    task automatic mfc0(input logic [4:0] rd, input logic [NIRQ-1:0] irq);
        step(1, 32'h1000, 0, 1, 5'b00000, rd, 6'd0, 32'h0, irq);
    endtask
    task automatic mtc0(input logic [4:0] rd, input logic [31:0] wd, input logic [NIRQ-1:0] irq);
        step(1, 32'h1004, 0, 1, 5'b00100, rd, 6'd0, wd, irq);
    endtask
    task automatic eret(input logic [NIRQ-1:0] irq);
        step(1, 32'h1008, 0, 1, 5'b10000, 5'd0, 6'b011000, 32'h0, irq);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        InstrValid = 0; PC = '0; IsSyscall = 0; IsCOP0 = 0;
        Rs = '0; Rd = '0; Funct = '0; WData = '0; IrqReq = '0;
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        do_reset();
        // Reset-state values with no instruction in flight.
        #1;
        check("rst_RData",      RData,             32'h0);
        check("rst_Stall",      32'(Stall),        32'h0);
        check("rst_PCRedirect", 32'(PCRedirect),   32'h0);
        check("rst_RedirectPC", RedirectPC,        32'h0);
        check("rst_InHandler",  32'(InHandler),    32'h0);

        // Interrupt on line 0 at PC 0x40.
        mtc0(5'd12, 32'h0000_0101, 4'b0001);
        nop(32'h40, 4'b0001);
        nop(32'h44, 4'b0000);
        mfc0(5'd14, 4'b0000);
        mfc0(5'd13, 4'b0000);
        eret(4'b0000);
        nop(32'h40, 4'b0000);

        // Syscall with interrupts disabled.
        mtc0(5'd12, 32'h0, 4'b0000);
        sysc(32'h100, 4'b0000);
        nop(32'h104, 4'b0000);
        mfc0(5'd13, 4'b0000);
        mfc0(5'd14, 4'b0000);
        eret(4'b0000);
        nop(32'h104, 4'b0000);
        mfc0(5'd12, 4'b0000);

        // Syscall and interrupt in the same cycle: interrupt wins.
        mtc0(5'd12, 32'h0000_0401, 4'b0100);
        sysc(32'h200, 4'b0100);
        nop(32'h204, 4'b0000);
        mfc0(5'd14, 4'b0000);

        // Inside the handler: interrupts masked, syscall ignored, EPC rewritten.
        nop(32'h184, 4'b1111);
        sysc(32'h188, 4'b1111);
        mfc0(5'd13, 4'b1111);
        mfc0(5'd14, 4'b0000);
        mtc0(5'd14, 32'h300, 4'b0000);
        eret(4'b0000);
        nop(32'h0, 4'b0000);
        nop(32'h300, 4'b0000);

        // Status write-back, unmapped register, PC wrap on syscall.
        mtc0(5'd12, 32'h0000_0F01, 4'b0000);
        mfc0(5'd12, 4'b0000);
        mfc0(5'd5, 4'b0000);
        step(0, 32'h500, 0, 0, 5'd0, 5'd0, 6'd0, 32'h0, 4'b0001);
        step(0, 32'h500, 0, 0, 5'd0, 5'd0, 6'd0, 32'h0, 4'b0000);
        mtc0(5'd12, 32'h0, 4'b0000);
        sysc(32'hFFFF_FFFC, 4'b0000);
        nop(32'h0, 4'b0000);
        mfc0(5'd14, 4'b0000);
        eret(4'b0000);
        nop(32'h0, 4'b0000);

        // Reset in the middle of ENTER.
        sysc(32'h600, 4'b0000);
        nop(32'h604, 4'b0000);
        #1;
        check("enter_Stall", 32'(Stall), 32'h1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_Stall",      32'(Stall),      32'h0);
        check("arst_PCRedirect", 32'(PCRedirect), 32'h0);
        check("arst_RedirectPC", RedirectPC,      32'h0);
        check("arst_InHandler",  32'(InHandler),  32'h0);
        do_reset();
        mfc0(5'd12, 4'b0000);
        mfc0(5'd13, 4'b0000);
        mfc0(5'd14, 4'b0000);
        nop(32'h700, 4'b0000);

        // Randomised instruction mix.
        for (int n = 0; n < 800; n++) begin
            int unsigned     kind;
            logic [31:0]     pc, wd;
            logic [NIRQ-1:0] irq;
            bit              iv;
            kind = $urandom_range(0, 99);
            iv   = ($urandom_range(0, 9) != 0);
            pc   = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            irq  = ($urandom_range(0, 3) == 0) ? NIRQ'($urandom()) : IrqReq;
            if (kind < 40)
                step(iv, pc, 0, 0, 5'd0, 5'd0, 6'd0, 32'h0, irq);
            else if (kind < 50)
                step(iv, pc, 1, 0, 5'd0, 5'd0, 6'd0, 32'h0, irq);
            else if (kind < 62)
                step(iv, pc, 0, 1, 5'b00000, 5'($urandom_range(10, 16)), 6'd0, 32'h0, irq);
            else if (kind < 76) begin
                wd = $urandom();
                if ($urandom_range(0, 3) != 0) wd = wd & 32'hFFFF_FFFD;
                step(iv, pc, 0, 1, 5'b00100, 5'($urandom_range(11, 15)), 6'd0, wd, irq);
            end else if (kind < 90)
                step(iv, pc, 0, 1, 5'b10000, 5'd0, 6'b011000, 32'h0, irq);
            else
                step(iv, pc, 0, 1, 5'($urandom()), 5'($urandom()), 6'($urandom()), $urandom(), irq);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cop0_exc_ctrl.md
Name: cop0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the single-cycle MIPS core.
- Holds the Status, Cause and EPC registers, and services mfc0, mtc0 and eret.
- Arbitrates syscall traps against external interrupt lines, then sequences the trap entry and return through a small FSM.
- Sits beside the control unit: consumes its IsSyscall/IsCOP0 decode and drives PC redirect, flush and stall back into the datapath.

Parameters:
NUM_IRQ, 4, number of external interrupt lines (1..8)
HANDLER_ADDR, 32'h0000_0180, trap handler entry PC

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
InstrValid  input  1  current instruction commits this cycle
PC  input  32  PC of current instruction
IsSyscall  input  1  decode: syscall
IsCOP0  input  1  decode: opcode 010000
Rs  input  5  instr[25:21]; 00000=mfc0, 00100=mtc0, 10000 with Funct 011000=eret
Rd  input  5  instr[15:11], CP0 register select
Funct  input  6  instr[5:0]
WData  input  32  rt value for mtc0
IrqReq  input  NUM_IRQ  level-sensitive interrupt requests, asynchronous to instruction flow
RData  output  32  mfc0 read data (combinational)
Flush  output  1  kill RegWrite/MemWrite of current instruction (combinational)
Stall  output  1  hold PC, block commit this cycle
PCRedirect  output  1  load RedirectPC into PC at next edge
RedirectPC  output  32  redirect target
IntAck  output  NUM_IRQ  one-hot acknowledge pulse
InHandler  output  1  mirror of Status.EXL

Behaviour:
- Reset state: FSM=RUN; Status=0; Cause=0; EPC=0; sync flop=0. Outputs: RData=0, Flush=0, Stall=0, PCRedirect=0, RedirectPC=0, IntAck=0, InHandler=0.
- Status (reg 12): bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM. All other bits read 0.
- Cause (reg 13): bits[6:2] ExcCode (0=Int, 8=Sys), bits[8+NUM_IRQ-1:8] IP. Read-only.
- EPC (reg 14): 32 bits.
- Any other Rd reads 0 and ignores writes.
- IP = IrqReq registered through one flop, updated every cycle.
- IntTake = InstrValid & IE & ~EXL & |(IP & IM), state RUN.
- SysTake = InstrValid & IsSyscall & ~EXL, state RUN.
- States: RUN, ENTER, HANDLER, RETURN.
- RUN, IntTake (has priority over SysTake; a same-cycle syscall is re-executed after return):
  - Flush=1; EPC<=PC; ExcCode<=0; EXL<=1.
  - IntAck: one-cycle pulse on the lowest-index set bit of IP&IM, same cycle.
  - Next state: ENTER.
- RUN, SysTake: EPC<=PC+4 (32-bit wrap); ExcCode<=8; EXL<=1; Flush=0; next state ENTER.
- ENTER (1 cycle): Stall=1, PCRedirect=1, RedirectPC=HANDLER_ADDR; next state HANDLER.
- HANDLER:
  - Interrupts are masked by EXL.
  - A syscall is ignored: no EPC/Cause update, and it commits as a NOP.
  - mfc0/mtc0 operate normally.
  - eret (IsCOP0, Rs=10000, Funct=011000, InstrValid): EXL<=0; next state RETURN.
- RETURN (1 cycle): Stall=1, PCRedirect=1, RedirectPC=EPC as of the eret commit cycle; next state RUN.
- An eret while in RUN is treated as a NOP.
- mtc0 (InstrValid, IsCOP0, Rs=00100): register write at the clock edge.
  - Writes are suppressed when Flush=1.
  - Writing EXL via mtc0 does not change the FSM state.
  - An interrupt decision in the same cycle uses pre-write Status.
- mfc0 (IsCOP0, Rs=00000): RData = selected register (current value, combinational). RData=0 when not mfc0.
- Latency:
  - Trap: detected in cycle N, handler instruction first commits in cycle N+2.
  - eret: commits in cycle M, target commits in cycle M+2.
- InstrValid=0 in RUN: no trap is taken; IP still samples.
- Reset asserted mid-ENTER/RETURN aborts the redirect immediately: all outputs go to 0 asynchronously.

Test Plan:
- Reset, IE=1, IM=0001, IrqReq[0]=1, next valid instr at PC=0x40 -> Flush=1, IntAck=0001 in same cycle; EPC=0x40, ExcCode=0; next cycle Stall=1, PCRedirect=1, RedirectPC=0x180; InHandler=1.
- Syscall at PC=0x100, IE=0 -> Flush=0, EPC=0x104, Cause[6:2]=8; ENTER redirect to 0x180; then eret -> RETURN redirect 0x104, InHandler=0.
- Syscall and enabled IrqReq[2] in same cycle, PC=0x200 -> interrupt wins: EPC=0x200, ExcCode=0, IntAck=0100.
- In HANDLER: IrqReq=all ones, then a syscall -> no IntAck, EPC/Cause unchanged; mtc0 Rd=14 WData=0x300, eret -> RedirectPC=0x300.
- mtc0 Rd=12 WData=0x0000_0F01 -> mfc0 Rd=12 returns 0x0000_0F01 (NUM_IRQ=4); mfc0 Rd=5 returns 0; PC=0xFFFF_FFFC syscall -> EPC=0x0000_0000.
- Assert rst_n=0 during ENTER -> PCRedirect, Stall drop immediately; after release state=RUN, Status=Cause=EPC=0.
